neosd_wb_fifo: RTL and testbench

Parametrised Wishbone-side data buffer for the NEOSD controller: a pipelined Wishbone slave with a register window, a DEPTH-word FIFO and masked interrupt generation. It replaces the single-word DAT data register. Host transfers are decoupled from the DAT FSM, which connects through valid/ready streams (RX: card→host, TX: host→card).

---
 rtl/neosd_wb_fifo.sv | 166 ++++++++++++++++
 tb/tb_neosd_wb_fifo.sv | 343 ++++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/neosd_wb_fifo.sv
// neosd_wb_fifo: Wishbone-side DEPTH-word data buffer for the NEOSD controller.
// Pipelined Wishbone slave with CTRL/STATUS/IRQ_FLAG/IRQ_MASK/DATA registers,
// a first-word-fall-through FIFO shared by both directions, and masked IRQ.
// Ports:
//   clk_i, rstn_i                 clock, async active-low reset
//   wb_*                          pipelined Wishbone slave (stall is combinational)
//   irq_o                         registered |(IRQ_FLAG & IRQ_MASK)
//   rx_data_i/rx_valid_i/rx_ready_o  card->host stream from the DAT FSM
//   tx_data_o/tx_valid_o/tx_ready_i  host->card stream to the DAT FSM
module neosd_wb_fifo #(
  parameter int unsigned DEPTH    = 16,
  parameter bit          STALL_EN = 1'b1,
  parameter int unsigned RST_THR  = 8
) (
  input  logic        clk_i,
  input  logic        rstn_i,
  input  logic [7:0]  wb_adr_i,
  input  logic [31:0] wb_dat_i,
  input  logic        wb_we_i,
  input  logic [3:0]  wb_sel_i,
  input  logic        wb_stb_i,
  input  logic        wb_cyc_i,
  output logic        wb_stall_o,
  output logic        wb_ack_o,
  output logic [31:0] wb_dat_o,
  output logic        irq_o,
  input  logic [31:0] rx_data_i,
  input  logic        rx_valid_i,
  output logic        rx_ready_o,
  output logic [31:0] tx_data_o,
  output logic        tx_valid_o,
  input  logic        tx_ready_i
);

  localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int unsigned LW = AW + 1;
  localparam int unsigned CW = 10;  // threshold compare width, covers DEPTH=256 and THR=255

  localparam logic [7:0] ADR_CTRL   = 8'h00;
  localparam logic [7:0] ADR_STATUS = 8'h04;
  localparam logic [7:0] ADR_FLAG   = 8'h08;
  localparam logic [7:0] ADR_MASK   = 8'h0C;
  localparam logic [7:0] ADR_DATA   = 8'h10;

  localparam logic [LW-1:0] DEPTH_L = LW'(DEPTH);

  logic          dir_q;
  logic [7:0]    thr_q;
  logic [3:0]    mask_q;
  logic [3:0]    flag_q;
  logic [AW-1:0] wr_ptr_q, rd_ptr_q;
  logic [LW-1:0] level_q;
  logic [31:0]   mem [DEPTH];
  logic          ack_q;
  logic [31:0]   dat_q;
  logic          irq_q;

  logic        full, empty, access, sel_data, accept, wr_acc, rd_acc;
  logic        host_push, host_pop, rx_push, tx_pop, push, pop, flush;
  logic [31:0] push_data, rd_data;
  logic        thr_hit;
  logic [3:0]  flag_set, flag_w1c;

  // Bus decode and FIFO handshakes, all qualified by registered full/empty
  always_comb begin
    full       = (level_q == DEPTH_L);
    empty      = (level_q == '0);
    access     = wb_cyc_i & wb_stb_i;
    sel_data   = (wb_adr_i == ADR_DATA);
    wb_stall_o = STALL_EN & access & sel_data &
                 ((wb_we_i & dir_q & full) | (~wb_we_i & ~dir_q & empty));
    accept     = access & ~wb_stall_o;
    wr_acc     = accept & wb_we_i;
    rd_acc     = accept & ~wb_we_i;

    rx_ready_o = ~dir_q & ~full;
    tx_valid_o = dir_q & ~empty;
    tx_data_o  = mem[rd_ptr_q];

    host_push  = wr_acc & sel_data & dir_q & ~full & (wb_sel_i == 4'hF);
    host_pop   = rd_acc & sel_data & ~dir_q & ~empty;
    rx_push    = rx_valid_i & rx_ready_o;
    tx_pop     = tx_valid_o & tx_ready_i;
    // DIR selects the single possible producer and consumer
    push       = host_push | rx_push;
    pop        = host_pop | tx_pop;
    push_data  = dir_q ? wb_dat_i : rx_data_i;
    flush      = wr_acc & (wb_adr_i == ADR_CTRL) & wb_sel_i[0] & wb_dat_i[1];
  end

  // Register read mux
  always_comb begin
    rd_data = '0;
    case (wb_adr_i)
      ADR_CTRL:   rd_data = {16'h0, thr_q, 7'h0, dir_q};
      ADR_STATUS: rd_data = {14'h0, full, empty, 7'h0, 9'(level_q)};
      ADR_FLAG:   rd_data = {28'h0, flag_q};
      ADR_MASK:   rd_data = {28'h0, mask_q};
      ADR_DATA:   rd_data = host_pop ? mem[rd_ptr_q] : 32'h0;
      default:    rd_data = '0;
    endcase
  end

  // Flag sources; hardware sets take priority over a same-cycle W1C
  always_comb begin
    if (dir_q) thr_hit = (CW'(DEPTH) - CW'(level_q)) >= CW'(thr_q);
    else       thr_hit = CW'(level_q) >= CW'(thr_q);
    thr_hit     = thr_hit & (thr_q != 8'h0);
    flag_set[0] = thr_hit;
    flag_set[1] = wr_acc & sel_data & dir_q & full & (wb_sel_i == 4'hF);
    flag_set[2] = rd_acc & sel_data & ~dir_q & empty;
    flag_set[3] = accept & sel_data & (wb_we_i ^ dir_q);
    flag_w1c    = (wr_acc & (wb_adr_i == ADR_FLAG) & wb_sel_i[0]) ? wb_dat_i[3:0] : 4'h0;
  end

  // Control/status registers and bus response
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      dir_q  <= 1'b0;
      thr_q  <= 8'(RST_THR);
      mask_q <= '0;
      flag_q <= '0;
      ack_q  <= 1'b0;
      dat_q  <= '0;
      irq_q  <= 1'b0;
    end else begin
      if (wr_acc && (wb_adr_i == ADR_CTRL)) begin
        if (wb_sel_i[0]) dir_q <= wb_dat_i[0];
        if (wb_sel_i[1]) thr_q <= wb_dat_i[15:8];
      end
      if (wr_acc && (wb_adr_i == ADR_MASK) && wb_sel_i[0]) mask_q <= wb_dat_i[3:0];
      flag_q <= (flag_q & ~flag_w1c) | flag_set;
      ack_q  <= accept;
      dat_q  <= rd_acc ? rd_data : 32'h0;
      irq_q  <= |(flag_q & mask_q);
    end
  end

  // FIFO pointers and level; flush overrides any same-cycle push/pop
  always_ff @(posedge clk_i or negedge rstn_i) begin
    if (!rstn_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else if (flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (push) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_q <= rd_ptr_q + AW'(1);
      if (push && !pop)      level_q <= level_q + LW'(1);
      else if (pop && !push) level_q <= level_q - LW'(1);
    end
  end

  // Storage array, no reset needed
  always_ff @(posedge clk_i) begin
    if (push && !flush) mem[wr_ptr_q] <= push_data;
  end

  assign wb_ack_o = ack_q;
  assign wb_dat_o = dat_q;
  assign irq_o    = irq_q;

endmodule

// File: tb/tb_neosd_wb_fifo.sv
`timescale 1ns/1ps
// Bench for neosd_wb_fifo: instance 0 stalls (STALL_EN=1), instance 1 drops (STALL_EN=0).
// A queue-based reference model advances on each clock edge; a monitor compares outputs.
module tb_neosd_wb_fifo;
  localparam int unsigned DEPTH = 16;

  logic clk = 1'b0;
  logic rstn = 1'b0;
  always #5 clk = ~clk;

  logic        cyc[2], stb[2], we[2], rx_valid[2], tx_ready[2];
  logic [7:0]  adr[2];
  logic [31:0] wdat[2], rx_data[2];
  logic [3:0]  sel[2];
  logic        stall[2], ack[2], irq[2], rx_ready[2], tx_valid[2];
  logic [31:0] rdat[2], tx_data[2];

  for (genvar g = 0; g < 2; g++) begin : g_dut
    neosd_wb_fifo #(.DEPTH(DEPTH), .STALL_EN(g == 0), .RST_THR(8)) u_dut (
      .clk_i(clk), .rstn_i(rstn),
      .wb_adr_i(adr[g]), .wb_dat_i(wdat[g]), .wb_we_i(we[g]), .wb_sel_i(sel[g]),
      .wb_stb_i(stb[g]), .wb_cyc_i(cyc[g]), .wb_stall_o(stall[g]), .wb_ack_o(ack[g]),
      .wb_dat_o(rdat[g]), .irq_o(irq[g]),
      .rx_data_i(rx_data[g]), .rx_valid_i(rx_valid[g]), .rx_ready_o(rx_ready[g]),
      .tx_data_o(tx_data[g]), .tx_valid_o(tx_valid[g]), .tx_ready_i(tx_ready[g])
    );
  end

  // Reference model state
  logic [31:0] fq[2][$];
  logic [31:0] exp_q[2][$];
  logic [31:0] rcv[$];
  bit          m_dir[2];
  logic [7:0]  m_thr[2];
  logic [3:0]  m_mask[2], m_flag[2];
  bit          m_irq[2];
  logic [31:0] last_rd[2];
  bit          wdone;
  int          checks = 0;
  int          errors = 0;

  task automatic chk(input string n, input int u, input logic [31:0] a, input logic [31:0] e);
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s u%0d: got %h expected %h at %0t", n, u, a, e, $time);
    end
  endtask

  function automatic bit exp_stall(input int u);
    int sz;
    sz = fq[u].size();
    return (u == 0) && cyc[u] && stb[u] && (adr[u] == 8'h10) &&
           ((we[u] && m_dir[u] && sz == DEPTH) || (!we[u] && !m_dir[u] && sz == 0));
  endfunction

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      fq[u].delete();
      exp_q[u].delete();
      m_dir[u] = 1'b0; m_thr[u] = 8'd8; m_mask[u] = 4'h0; m_flag[u] = 4'h0; m_irq[u] = 1'b0;
    end
  endtask

  // One clock edge of the specified behaviour, computed from pre-edge state
  task automatic model_step(input int u);
    int sz;
    bit full, empty, acc, thr_c, flush, push, pop, n_dir;
    logic [31:0] rd, pv, tmp;
    logic [7:0]  n_thr;
    logic [3:0]  set, clr, n_mask;
    sz = fq[u].size(); full = (sz == DEPTH); empty = (sz == 0);
    acc = cyc[u] && stb[u] && !exp_stall(u);
    thr_c = (m_thr[u] != 0) &&
            (m_dir[u] ? (int'(DEPTH) - sz >= int'(m_thr[u])) : (sz >= int'(m_thr[u])));
    set = {3'b000, thr_c}; clr = 4'h0; rd = 32'h0; pv = 32'h0;
    flush = 0; push = 0; pop = 0;
    n_dir = m_dir[u]; n_thr = m_thr[u]; n_mask = m_mask[u];
    if (acc) begin
      case (adr[u])
        8'h00: if (we[u]) begin
                 if (sel[u][0]) begin n_dir = wdat[u][0]; flush = wdat[u][1]; end
                 if (sel[u][1]) n_thr = wdat[u][15:8];
               end else rd = {16'h0, m_thr[u], 7'h0, m_dir[u]};
        8'h04: rd = {14'h0, full, empty, 7'h0, 9'(sz)};
        8'h08: if (we[u]) begin if (sel[u][0]) clr = wdat[u][3:0]; end
               else rd = {28'h0, m_flag[u]};
        8'h0C: if (we[u]) begin if (sel[u][0]) n_mask = wdat[u][3:0]; end
               else rd = {28'h0, m_mask[u]};
        8'h10: if (we[u]) begin
                 if (!m_dir[u]) set[3] = 1'b1;
                 else if (sel[u] == 4'hF) begin
                   if (full) set[1] = 1'b1;
                   else begin push = 1; pv = wdat[u]; end
                 end
               end else begin
                 if (m_dir[u]) set[3] = 1'b1;
                 else if (empty) set[2] = 1'b1;
                 else begin pop = 1; rd = fq[u][0]; end
               end
        default: ;
      endcase
      exp_q[u].push_back(we[u] ? 32'h0 : rd);
    end
    if (rx_valid[u] && !m_dir[u] && !full) begin push = 1; pv = rx_data[u]; end
    if (tx_ready[u] && m_dir[u] && !empty) pop = 1;
    if (flush) fq[u].delete();
    else begin
      if (pop) tmp = fq[u].pop_front();
      if (push) fq[u].push_back(pv);
    end
    m_irq[u]  = |(m_flag[u] & m_mask[u]);
    m_flag[u] = (m_flag[u] & ~clr) | set;
    m_dir[u] = n_dir; m_thr[u] = n_thr; m_mask[u] = n_mask;
  endtask

  always @(posedge clk or negedge rstn) begin
    if (!rstn) model_reset();
    else begin model_step(0); model_step(1); end
  end

  // Monitor: scoreboard pop on each ack plus per-cycle output checks
  always @(negedge clk) begin
    if (rstn) begin
      for (int u = 0; u < 2; u++) begin
        if (ack[u]) begin
          if (exp_q[u].size() == 0) begin
            checks++; errors++;
            $display("FAIL unexpected_ack u%0d: got ack with data %h, expected no ack", u, rdat[u]);
          end else begin
            chk("wb_dat", u, rdat[u], exp_q[u].pop_front());
            last_rd[u] = rdat[u];
          end
        end else chk("wb_dat_idle", u, rdat[u], 32'h0);
        chk("stall", u, 32'(stall[u]), 32'(exp_stall(u)));
        chk("irq", u, 32'(irq[u]), 32'(m_irq[u]));
        chk("rx_ready", u, 32'(rx_ready[u]), 32'(!m_dir[u] && fq[u].size() < DEPTH));
        chk("tx_valid", u, 32'(tx_valid[u]), 32'(m_dir[u] && fq[u].size() > 0));
        if (m_dir[u] && fq[u].size() > 0) chk("tx_data", u, tx_data[u], fq[u][0]);
      end
    end
  end

  // Collects words consumed from the TX stream of instance 0
  always @(negedge clk) begin
    if (rstn && tx_valid[0] && tx_ready[0]) rcv.push_back(tx_data[0]);
  end

  task automatic idle(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic bus(input int u, input bit w, input logic [7:0] a, input logic [31:0] d,
                     input logic [3:0] s);
    int n;
    bit ok;
    cyc[u] = 1'b1; stb[u] = 1'b1; we[u] = w; adr[u] = a; wdat[u] = d; sel[u] = s; n = 0;
    forever begin
      @(negedge clk); ok = !stall[u];
      @(posedge clk); #1;
      if (ok) break;
      n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL bus_timeout u%0d: adr %h still stalled, expected accept", u, a);
        break;
      end
    end
    cyc[u] = 1'b0; stb[u] = 1'b0; we[u] = 1'b0;
  endtask

  task automatic rx_push(input int u, input logic [31:0] d);
    int n;
    bit ok;
    rx_valid[u] = 1'b1; rx_data[u] = d; n = 0;
    forever begin
      @(negedge clk); ok = rx_ready[u];
      @(posedge clk); #1;
      if (ok) break;
      n++;
      if (n > 500) begin
        checks++; errors++;
        $display("FAIL rx_timeout u%0d: rx_ready stayed 0, expected 1", u);
        break;
      end
    end
    rx_valid[u] = 1'b0;
  endtask

  task automatic rd_chk(input int u, input logic [7:0] a, input logic [31:0] e, input string n);
    last_rd[u] = 32'hDEAD_BEEF;
    bus(u, 1'b0, a, 32'h0, 4'hF);
    @(negedge clk); #1;
    chk(n, u, last_rd[u], e);
    @(posedge clk); #1;
  endtask

  logic [31:0] w[16];

  initial begin
    for (int u = 0; u < 2; u++) begin
      cyc[u] = 0; stb[u] = 0; we[u] = 0; adr[u] = 0; wdat[u] = 0; sel[u] = 0;
      rx_valid[u] = 0; rx_data[u] = 0; tx_ready[u] = 0; last_rd[u] = 0;
    end
    wdone = 0;
    model_reset();
    repeat (3) @(posedge clk);
    #1;
    for (int u = 0; u < 2; u++) begin
      chk("rst_ack", u, 32'(ack[u]), 0);
      chk("rst_dat", u, rdat[u], 0);
      chk("rst_irq", u, 32'(irq[u]), 0);
      chk("rst_tx_valid", u, 32'(tx_valid[u]), 0);
      chk("rst_rx_ready", u, 32'(rx_ready[u]), 1);
    end
    rstn = 1'b1;
    idle(2);
    rd_chk(0, 8'h00, 32'h0000_0800, "ctrl_rst");
    rd_chk(0, 8'h04, 32'h0001_0000, "status_rst");
    rd_chk(0, 8'h08, 32'h0, "flag_rst");
    rd_chk(0, 8'h0C, 32'h0, "mask_rst");
    rd_chk(0, 8'h40, 32'h0, "unmapped");

    // RX threshold interrupt
    bus(0, 1, 8'h00, 32'h0000_0400, 4'h2);
    bus(0, 1, 8'h0C, 32'h1, 4'hF);
    for (int i = 0; i < 4; i++) rx_push(0, 32'hA0 + i);
    idle(1); chk("irq_thr_early", 0, 32'(irq[0]), 0);
    idle(1); chk("irq_thr", 0, 32'(irq[0]), 1);
    for (int i = 0; i < 4; i++) rd_chk(0, 8'h10, 32'hA0 + i, "rx_read");
    rd_chk(0, 8'h04, 32'h0001_0000, "rx_level0");
    bus(0, 1, 8'h08, 32'hF, 4'hF);

    // TX fill with stall on full
    bus(0, 1, 8'h00, 32'h1, 4'h1);
    for (int i = 0; i < 16; i++) begin
      w[i] = $urandom;
      bus(0, 1, 8'h10, w[i], 4'hF);
    end
    rd_chk(0, 8'h04, 32'h0002_0010, "status_full");
    fork
      bus(0, 1, 8'h10, 32'h1717_1717, 4'hF);
      begin
        idle(2);
        chk("stall_full", 0, 32'(stall[0]), 1);
        chk("tx_head0", 0, tx_data[0], w[0]);
        tx_ready[0] = 1'b1;
        @(posedge clk); #1;
        tx_ready[0] = 1'b0;
        chk("tx_head1", 0, tx_data[0], w[1]);
      end
    join
    rd_chk(0, 8'h04, 32'h0002_0010, "status_refill");
    tx_ready[0] = 1'b1; idle(20); tx_ready[0] = 1'b0;
    rd_chk(0, 8'h04, 32'h0001_0000, "status_drained");

    // Pointer wrap with random consumer
    rcv.delete();
    fork
      begin
        for (int i = 0; i < 40; i++) bus(0, 1, 8'h10, 32'h100 + i, 4'hF);
        wdone = 1;
      end
      begin
        for (int n = 0; n < 3000; n++) begin
          tx_ready[0] = ($urandom & 1) != 0;
          @(posedge clk); #1;
          if (wdone && fq[0].size() == 0) break;
        end
        tx_ready[0] = 1'b0;
      end
    join
    chk("wrap_count", 0, rcv.size(), 40);
    for (int i = 0; i < 40 && i < rcv.size(); i++) chk("wrap_word", 0, rcv[i], 32'h100 + i);

    // Simultaneous push/pop and flush in RX
    bus(0, 1, 8'h00, 32'h0, 4'h1);
    for (int i = 0; i < 3; i++) rx_push(0, 32'hB0 + i);
    fork
      rx_push(0, 32'hB3);
      rd_chk(0, 8'h10, 32'hB0, "simul_pop");
    join
    rd_chk(0, 8'h04, 32'h0000_0003, "simul_level");
    fork
      rx_push(0, 32'hB4);
      bus(0, 1, 8'h00, 32'h2, 4'h1);
    join
    rd_chk(0, 8'h04, 32'h0001_0000, "flush_level");
    rx_push(0, 32'hC0);
    rd_chk(0, 8'h10, 32'hC0, "post_flush_word");

    // Direction and byte enables
    bus(0, 1, 8'h08, 32'hF, 4'hF);
    rd_chk(0, 8'h08, 32'h0, "flag_clear");
    bus(0, 1, 8'h10, 32'hDEAD, 4'hF);
    rd_chk(0, 8'h08, 32'h8, "direrr");
    rd_chk(0, 8'h04, 32'h0001_0000, "direrr_nopush");
    bus(0, 1, 8'h00, 32'h1, 4'h1);
    bus(0, 1, 8'h10, 32'h1234, 4'h3);
    rd_chk(0, 8'h04, 32'h0001_0000, "partial_sel");
    bus(0, 1, 8'h00, 32'h0500, 4'h2);
    rd_chk(0, 8'h00, 32'h0000_0501, "ctrl_sel2");

    // Drop mode: underflow, overflow, W1C
    rd_chk(1, 8'h10, 32'h0, "unf_data");
    rd_chk(1, 8'h08, 32'h4, "unf_flag");
    bus(1, 1, 8'h00, 32'h1, 4'h1);
    for (int i = 0; i < 17; i++) bus(1, 1, 8'h10, 32'h200 + i, 4'hF);
    rd_chk(1, 8'h04, 32'h0002_0010, "ovf_level");
    rd_chk(1, 8'h08, 32'h7, "ovf_flag");
    bus(1, 1, 8'h08, 32'h6, 4'hF);
    rd_chk(1, 8'h08, 32'h1, "w1c_flag");
    tx_ready[1] = 1'b1; idle(20); tx_ready[1] = 1'b0;

    idle(2);
    chk("pending_acks", 0, exp_q[0].size() + exp_q[1].size(), 0);

    // Reset during an in-flight access
    cyc[0] = 1; stb[0] = 1; we[0] = 0; adr[0] = 8'h00; sel[0] = 4'hF;
    @(posedge clk); #1;
    cyc[0] = 0; stb[0] = 0;
    rstn = 1'b0;
    #1;
    chk("rst_mid_ack", 0, 32'(ack[0]), 0);
    chk("rst_mid_dat", 0, rdat[0], 0);
    idle(2);
    rstn = 1'b1;
    idle(1);
    rd_chk(0, 8'h00, 32'h0000_0800, "ctrl_after_rst");
    idle(2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog: simulation still running, expected completion");
    $fatal(1, "watchdog");
  end

endmodule
